// File: rtl/jtpopeye_dma.sv
// Object DMA engine: on each VB rise it takes the Z80 bus and copies LEN bytes from the top
// 1 kB of main RAM into the object buffer through a fixed-latency read pipeline.
module jtpopeye_dma #(
  parameter int unsigned LEN    = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       VB,
  output logic       busrq_n,
  input  logic       busak_n,
  output logic       dma_cs,
  output logic [9:0] AD_DMA,
  input  logic [7:0] DD_DMA,
  output logic [9:0] obj_addr,
  output logic [7:0] obj_din,
  output logic       obj_we,
  output logic       INITEO,
  output logic       dma_done
);
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 11;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, RUN, DRAIN, REL} state_t;

  state_t                    state_q, state_d;
  logic                      busrq_q, busrq_d;
  logic                      cs_q, cs_d;
  logic [AW-1:0]             ad_q, ad_d;
  logic [AW-1:0]             oaddr_q, oaddr_d;
  logic [DW-1:0]             odin_q, odin_d;
  logic                      we_q, we_d;
  logic                      init_q, init_d;
  logic                      done_q, done_d;
  logic                      abort_q, abort_d;
  logic                      vbl_q, vbl_d;
  logic [CW-1:0]             rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]             wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0]         vld_q, vld_d;
  logic [RD_LAT-1:0][AW-1:0] idx_q, idx_d;
  logic                      trig;
  logic                      shift_en;
  logic                      push;
  logic [AW-1:0]             push_idx;

  assign trig = VB & ~vbl_q & cen;

  // Sequencing: every state change and pipeline step happens on a cen tick only
  always_comb begin
    state_d  = state_q;
    busrq_d  = busrq_q;
    cs_d     = cs_q;
    ad_d     = ad_q;
    oaddr_d  = oaddr_q;
    odin_d   = odin_q;
    we_d     = 1'b0;
    init_d   = init_q;
    done_d   = 1'b0;
    abort_d  = abort_q;
    vbl_d    = vbl_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    shift_en = 1'b0;
    push     = 1'b0;
    push_idx = '0;
    if (cen) begin
      vbl_d = VB;
      unique case (state_q)
        IDLE: if (trig) begin
          busrq_d = 1'b0;
          init_d  = 1'b1;
          state_d = REQ;
        end
        REQ: if (!busak_n) begin
          cs_d     = 1'b1;
          ad_d     = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          abort_d  = 1'b0;
          shift_en = 1'b1;
          push     = 1'b1;
          state_d  = (LAST == '0) ? DRAIN : RUN;
        end
        RUN, DRAIN: begin
          if (busak_n) begin
            // Bus taken away under us: drop everything in flight
            cs_d    = 1'b0;
            busrq_d = 1'b1;
            abort_d = 1'b1;
            vld_d   = '0;
            state_d = REL;
          end else begin
            shift_en = 1'b1;
            if (state_q == RUN) begin
              push     = 1'b1;
              push_idx = ad_q + 1'b1;
              ad_d     = push_idx;
              rd_cnt_d = rd_cnt_q + 1'b1;
              if (rd_cnt_q + 1'b1 == LAST) state_d = DRAIN;
            end
            if (vld_q[RD_LAT-1]) begin
              oaddr_d  = idx_q[RD_LAT-1];
              odin_d   = DD_DMA;
              we_d     = 1'b1;
              wr_cnt_d = wr_cnt_q + 1'b1;
              if (wr_cnt_q == LAST) begin
                cs_d    = 1'b0;
                busrq_d = 1'b1;
                state_d = REL;
              end
            end
          end
        end
        REL: if (busak_n) begin
          init_d  = 1'b0;
          done_d  = ~abort_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (shift_en) begin
        for (int k = 1; k < int'(RD_LAT); k++) begin
          vld_d[k] = vld_q[k-1];
          idx_d[k] = idx_q[k-1];
        end
        vld_d[0] = push;
        idx_d[0] = push_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busrq_q  <= 1'b1;
      cs_q     <= 1'b0;
      ad_q     <= '0;
      oaddr_q  <= '0;
      odin_q   <= '0;
      we_q     <= 1'b0;
      init_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      vbl_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      vld_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      busrq_q  <= busrq_d;
      cs_q     <= cs_d;
      ad_q     <= ad_d;
      oaddr_q  <= oaddr_d;
      odin_q   <= odin_d;
      we_q     <= we_d;
      init_q   <= init_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      vbl_q    <= vbl_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
    end
  end

  assign busrq_n  = busrq_q;
  assign dma_cs   = cs_q;
  assign AD_DMA   = ad_q;
  assign obj_addr = oaddr_q;
  assign obj_din  = odin_q;
  assign obj_we   = we_q;
  assign INITEO   = init_q;
  assign dma_done = done_q;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Bench for jtpopeye_dma: three builds (1024/lat2, 16/lat1, 16/lat3) checked against a
// transfer-level model of main RAM contents, write order and timing.
`timescale 1ns/1ps
module tb_jtpopeye_dma;
  localparam int NI = 3;

  function automatic int unsigned len_of(input int g);
    return (g == 0) ? 1024 : 16;
  endfunction
  function automatic int unsigned lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 3;
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic [NI-1:0] vb;
  logic [NI-1:0] busak_n;
  logic [NI-1:0] busrq_v, cs_v, we_v, init_v, done_v;
  logic [9:0]    ad_v    [NI];
  logic [9:0]    oaddr_v [NI];
  logic [7:0]    dd_v    [NI];
  logic [7:0]    odin_v  [NI];
  logic [7:0]    mem     [1024];

  int n_checks = 0;
  int n_fail   = 0;
  int cen_div  = 1;

  initial forever #5 clk = ~clk;

  // cen changes on the falling edge; cen_div==0 means a random 1-in-3 enable
  initial begin
    int cdc;
    cdc = 0;
    cen = 1'b0;
    forever begin
      @(negedge clk);
      if (cen_div == 0) cen = ($urandom_range(0, 2) == 0);
      else begin
        cdc = (cdc + 1) % cen_div;
        cen = (cdc == 0);
      end
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_d
    localparam int unsigned R = lat_of(g);
    logic [9:0] pipe [3];
    jtpopeye_dma #(.LEN(len_of(g)), .RD_LAT(R)) u_dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .VB(vb[g]),
      .busrq_n(busrq_v[g]), .busak_n(busak_n[g]), .dma_cs(cs_v[g]),
      .AD_DMA(ad_v[g]), .DD_DMA(dd_v[g]), .obj_addr(oaddr_v[g]), .obj_din(odin_v[g]),
      .obj_we(we_v[g]), .INITEO(init_v[g]), .dma_done(done_v[g])
    );
    // Main RAM: data for an address is readable RD_LAT cen ticks after the address is set
    always @(posedge clk) if (cen) begin
      pipe[0] <= ad_v[g];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign dd_v[g] = (R == 1) ? mem[ad_v[g]] : mem[pipe[(R >= 2) ? R - 2 : 0]];
  end

  // Transfer-level observer: write order, data, timing relative to the grant tick
  int         tick = 0;
  int         nwe[NI], ndone[NI], xwr[NI], gtick[NI], first_off[NI], last_off[NI];
  int         order_err[NI], data_err[NI], offcen[NI], dwide[NI];
  logic [NI-1:0] cs_prev = '0, done_prev = '0;
  logic [7:0] obuf [NI][1024];
  logic       c_edge;

  always begin
    @(posedge clk);
    c_edge = cen;
    #1;
    if (c_edge) tick++;
    for (int g = 0; g < NI; g++) begin
      if (cs_v[g] === 1'b1 && cs_prev[g] !== 1'b1) begin
        xwr[g]   = 0;
        gtick[g] = tick;
      end
      if (we_v[g] === 1'b1) begin
        if (!c_edge) offcen[g]++;
        if (int'(oaddr_v[g]) != xwr[g]) order_err[g]++;
        if (odin_v[g] !== mem[oaddr_v[g]]) data_err[g]++;
        obuf[g][oaddr_v[g]] = odin_v[g];
        if (xwr[g] == 0) first_off[g] = tick - gtick[g];
        last_off[g] = tick - gtick[g];
        xwr[g]++;
        nwe[g]++;
      end
      if (done_v[g] === 1'b1) begin
        ndone[g]++;
        if (done_prev[g] === 1'b1) dwide[g]++;
      end
    end
    cs_prev   = cs_v;
    done_prev = done_v;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cen(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (cen) k++;
      #2;
    end
  endtask

  task automatic wait_busrq(input int g, input logic v, input string tag);
    int t = 0;
    while (busrq_v[g] !== v && t < 60000) begin
      @(posedge clk); #2; t++;
    end
    check(tag, 32'(busrq_v[g]), 32'(v));
  endtask

  task automatic wait_idle(input int g, input string tag);
    int t = 0;
    while (init_v[g] !== 1'b0 && t < 2000) begin
      @(posedge clk); #2; t++;
    end
    check(tag, 32'(init_v[g]), 32'd0);
  endtask

  task automatic wait_we(input int g, input int target, input string tag);
    int t = 0;
    while (nwe[g] < target && t < 20000) begin
      @(posedge clk); #2; t++;
    end
    check(tag, nwe[g], target);
  endtask

  task automatic xfer(input int g, input int dly, input bit mid_vb, output int nw, output int nd);
    int w0 = nwe[g];
    int d0 = ndone[g];
    vb[g] = 1'b1;
    wait_busrq(g, 1'b0, "busrq_req");
    wait_cen(dly);
    busak_n[g] = 1'b0;
    vb[g] = 1'b0;
    if (mid_vb) begin
      wait_cen(300);
      vb[g] = 1'b1;
      wait_cen(2);
      vb[g] = 1'b0;
    end
    wait_busrq(g, 1'b1, "busrq_rel");
    wait_cen(2);
    busak_n[g] = 1'b1;
    wait_idle(g, "initeo_clr");
    wait_cen(2);
    nw = nwe[g] - w0;
    nd = ndone[g] - d0;
  endtask

  initial begin
    int w0, d0, nw, nd, mism;
    rst_n   = 1'b0;
    vb      = '0;
    busak_n = '1;
    cen_div = 1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busrq_n", 32'(busrq_v), 32'h7);
    check("rst_dma_cs", 32'(cs_v), 0);
    check("rst_initeo", 32'(init_v), 0);
    check("rst_dma_done", 32'(done_v), 0);
    check("rst_obj_we", 32'(we_v), 0);
    check("rst_ad_dma", 32'(ad_v[0]), 0);
    check("rst_obj_addr", 32'(oaddr_v[0]), 0);
    check("rst_obj_din", 32'(odin_v[0]), 0);
    rst_n = 1'b1;
    wait_cen(3);

    // Bus never granted: must sit in request
    vb[0] = 1'b1;
    wait_busrq(0, 1'b0, "t5_busrq_req");
    vb[0] = 1'b0;
    w0 = nwe[0];
    wait_cen(10000);
    check("t5_busrq_n", 32'(busrq_v[0]), 0);
    check("t5_initeo", 32'(init_v[0]), 1);
    check("t5_dma_cs", 32'(cs_v[0]), 0);
    check("t5_no_we", nwe[0] - w0, 0);

    // Grant, then reset after 100 writes
    busak_n[0] = 1'b0;
    wait_we(0, w0 + 100, "t1_100_writes");
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("t1_busrq_n", 32'(busrq_v[0]), 1);
    check("t1_dma_cs", 32'(cs_v[0]), 0);
    check("t1_initeo", 32'(init_v[0]), 0);
    busak_n[0] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_cen(20);
    check("t1_no_more_we", nwe[0] - w0, 100);

    // Full 1 kB copy, cen every 4 clk, grant 3 cen late, extra VB rise mid-run
    cen_div = 4;
    xfer(0, 3, 1'b1, nw, nd);
    check("t2_writes", nw, 1024);
    check("t2_done", nd, 1);
    check("t2_first_off", first_off[0], 2);
    check("t2_last_off", last_off[0], 1025);
    check("t2_order", order_err[0], 0);
    check("t2_data", data_err[0], 0);
    check("t2_we_on_cen", offcen[0], 0);
    check("t2_done_width", dwide[0], 0);
    check("t2_busrq_n", 32'(busrq_v[0]), 1);
    check("t2_dma_cs", 32'(cs_v[0]), 0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (obuf[0][i] !== (8'(i) ^ 8'h5A)) mism++;
    check("t2_objbuf", mism, 0);
    d0 = ndone[0];
    wait_cen(30);
    check("t4_no_queue_busrq", 32'(busrq_v[0]), 1);
    check("t4_no_queue_done", ndone[0] - d0, 0);

    // Fresh transfer with random data and random cen
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    cen_div = 0;
    xfer(0, int'($urandom_range(0, 5)), 1'b0, nw, nd);
    check("t4_writes", nw, 1024);
    check("t4_done", nd, 1);
    check("t4_order", order_err[0], 0);
    check("t4_data", data_err[0], 0);
    check("t4_first_off", first_off[0], 2);
    check("t4_last_off", last_off[0], 1025);
    check("t4_we_on_cen", offcen[0], 0);

    // Bus yanked after 50 writes
    cen_div = 2;
    w0 = nwe[0];
    d0 = ndone[0];
    vb[0] = 1'b1;
    wait_busrq(0, 1'b0, "t6_busrq_req");
    wait_cen(1);
    busak_n[0] = 1'b0;
    vb[0] = 1'b0;
    wait_we(0, w0 + 50, "t6_50_writes");
    busak_n[0] = 1'b1;
    wait_cen(1);
    check("t6_dma_cs", 32'(cs_v[0]), 0);
    check("t6_busrq_n", 32'(busrq_v[0]), 1);
    wait_idle(0, "t6_initeo");
    wait_cen(4);
    check("t6_writes", nwe[0] - w0, 50);
    check("t6_no_done", ndone[0] - d0, 0);

    // Short builds with read latency 1 and 3
    cen_div = 0;
    for (int g = 1; g < NI; g++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      xfer(g, 2, 1'b0, nw, nd);
      check($sformatf("t3_writes_g%0d", g), nw, 16);
      check($sformatf("t3_done_g%0d", g), nd, 1);
      check($sformatf("t3_first_off_g%0d", g), first_off[g], lat_of(g));
      check($sformatf("t3_last_off_g%0d", g), last_off[g], 15 + lat_of(g));
      check($sformatf("t3_order_g%0d", g), order_err[g], 0);
      check($sformatf("t3_data_g%0d", g), data_err[g], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
